full_adder_1: RTL and testbench



---
 rtl/full_adder_1_pkg.sv | 13 +
 rtl/full_adder_1_core.sv | 16 +
 rtl/full_adder_1.sv | 66 ++++++
 tb/tb_full_adder_1.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/full_adder_1_pkg.sv
// Shared constants and types for the full_adder_1 leaf cell.
package full_adder_1_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef logic [CNT_W_DEFAULT-1:0] carry_cnt_t;

  // Ideal two-bit result of x + y + cin, handy for building wider adders.
  function automatic logic [1:0] add3(input logic a, input logic b, input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/full_adder_1_core.sv
// Purely combinational sum / carry equations of the full adder; no state.
module full_adder_1_core
  import full_adder_1_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Continuous assigns keep X/Z on any input visible on the outputs.
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/full_adder_1.sv
// Full adder with registered result; FULL_ADDER_1_CARRY_CNT_EN adds a saturating carry-event counter.
module full_adder_1
  import full_adder_1_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             y,
  input  logic             cin,
  output logic             s,
  output logic             cout,
`ifdef FULL_ADDER_1_CARRY_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] carry_cnt,
`endif
  output logic             s_q,
  output logic             cout_q
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("full_adder_1: CNT_W must be at least 1");
  end

  full_adder_1_core u_core (
    .x    (x),
    .y    (y),
    .cin  (cin),
    .s    (s),
    .cout (cout)
  );

  // Stage p1: registered copy of the combinational result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s;
      cout_q <= cout;
    end
  end

`ifdef FULL_ADDER_1_CARRY_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == {CNT_W{1'b1}}) ? val : val + 1'b1;
  endfunction

  logic [CNT_W-1:0] cnt_p1;

  // Clear has priority over a carry event on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (cnt_clr) begin
      cnt_p1 <= '0;
    end else if (cout) begin
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign carry_cnt = cnt_p1;
`endif

endmodule

// File: tb/tb_full_adder_1.sv
// Directed self-checking bench for full_adder_1 (counter steps run when FULL_ADDER_1_CARRY_CNT_EN is defined).
module tb_full_adder_1;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic x, y, cin;
  logic s, cout, s_q, cout_q;
`ifdef FULL_ADDER_1_CARRY_CNT_EN
  logic             cnt_clr;
  logic [CNT_W-1:0] carry_cnt;
`endif

  int total = 0;
  int bad   = 0;

  full_adder_1 #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .s         (s),
    .cout      (cout),
`ifdef FULL_ADDER_1_CARRY_CNT_EN
    .cnt_clr   (cnt_clr),
    .carry_cnt (carry_cnt),
`endif
    .s_q       (s_q),
    .cout_q    (cout_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  logic [1:0] exp_sc [8];

  initial begin
    // {s, cout} for {x,y,cin} = 0..7
    exp_sc[0] = 2'b00; exp_sc[1] = 2'b10; exp_sc[2] = 2'b10; exp_sc[3] = 2'b01;
    exp_sc[4] = 2'b10; exp_sc[5] = 2'b01; exp_sc[6] = 2'b01; exp_sc[7] = 2'b11;

    rst_n = 1'b0;
    {x, y, cin} = 3'b000;
`ifdef FULL_ADDER_1_CARRY_CNT_EN
    cnt_clr = 1'b0;
`endif
    #1;
    check("reset_s_q", {7'd0, s_q}, 8'd0);
    check("reset_cout_q", {7'd0, cout_q}, 8'd0);
`ifdef FULL_ADDER_1_CARRY_CNT_EN
    check("reset_cnt", {4'd0, carry_cnt}, 8'd0);
`endif

    // Exhaustive combinational sweep, performed while still in reset
    for (int i = 0; i < 8; i++) begin
      {x, y, cin} = 3'(i);
      #1;
      check($sformatf("comb_s_%0d", i), {7'd0, s}, {7'd0, exp_sc[i][1]});
      check($sformatf("comb_cout_%0d", i), {7'd0, cout}, {7'd0, exp_sc[i][0]});
    end

    x = 1'bx; y = 1'b0; cin = 1'b0;
    #1;
    check("xprop_s", {7'd0, s}, {7'd0, 1'bx});

    // Registered path
    @(negedge clk);
    rst_n = 1'b1;
    {x, y, cin} = 3'b001;
    @(posedge clk); #1;
    check("reg_first_s_q", {7'd0, s_q}, 8'd1);
    check("reg_first_cout_q", {7'd0, cout_q}, 8'd0);
    {x, y, cin} = 3'b110;
    #1;
    check("reg_hold_s_q", {7'd0, s_q}, 8'd1);
    check("reg_hold_cout_q", {7'd0, cout_q}, 8'd0);
    @(posedge clk); #1;
    check("reg_new_s_q", {7'd0, s_q}, 8'd0);
    check("reg_new_cout_q", {7'd0, cout_q}, 8'd1);

    // Asynchronous reset between edges
    {x, y, cin} = 3'b001;
    @(posedge clk); #1;
    check("pre_rst_s_q", {7'd0, s_q}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_s_q", {7'd0, s_q}, 8'd0);
    check("arst_cout_q", {7'd0, cout_q}, 8'd0);
`ifdef FULL_ADDER_1_CARRY_CNT_EN
    check("arst_cnt", {4'd0, carry_cnt}, 8'd0);
`endif
    check("arst_s", {7'd0, s}, 8'd1);
    check("arst_cout", {7'd0, cout}, 8'd0);
    {x, y, cin} = 3'b111;
    #1;
    check("arst_follow_s", {7'd0, s}, 8'd1);
    check("arst_follow_cout", {7'd0, cout}, 8'd1);
    @(posedge clk); #1;
    check("arst_held_s_q", {7'd0, s_q}, 8'd0);

`ifdef FULL_ADDER_1_CARRY_CNT_EN
    // Counter: five carry edges then three quiet edges
    @(negedge clk);
    {x, y, cin} = 3'b110;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("cnt_after5", {4'd0, carry_cnt}, 8'd5);
    {x, y, cin} = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("cnt_hold5", {4'd0, carry_cnt}, 8'd5);

    // Saturation, then clear wins over a carry event
    {x, y, cin} = 3'b011;
    repeat (20) @(posedge clk);
    #1;
    check("cnt_sat", {4'd0, carry_cnt}, 8'd15);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    check("cnt_clr", {4'd0, carry_cnt}, 8'd0);
    cnt_clr = 1'b0;
    @(posedge clk); #1;
    check("cnt_restart", {4'd0, carry_cnt}, 8'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
